// File: rtl/alu_op_sequencer.sv
// Issue stage for a 32-bit combinational ALU: command FIFO, registered ALU operands,
// one-cycle result capture with flag normalisation. Optional feature macro: ALU_SEQ_CHAIN_EN.
module alu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_opcode,
  input  logic [31:0]   in_a,
  input  logic [31:0]   in_b,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic          in_chain,
`endif
  output logic [31:0]   alu_a,
  output logic [31:0]   alu_b,
  output logic [2:0]    alu_op,
  input  logic [31:0]   alu_c,
  input  logic [2:0]    alu_d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_c,
  output logic          out_zero,
  output logic          out_ovf,
  output logic          out_neg,
  output logic [2:0]    out_opcode,
  input  logic          clr_sticky,
  output logic          ovf_sticky,
  output logic          busy,
  output logic [CW-1:0] fifo_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_SLA = 3'b000;
  localparam logic [2:0] OP_SRA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef struct packed {
`ifdef ALU_SEQ_CHAIN_EN
    logic        chain;
`endif
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  state_e        state_q, state_d;
  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   alu_a_q, alu_a_d;
  logic [31:0]   alu_b_q, alu_b_d;
  logic [2:0]    alu_op_q, alu_op_d;

  logic [31:0]   out_c_q, out_c_d;
  logic          out_zero_q, out_zero_d;
  logic          out_ovf_q, out_ovf_d;
  logic          out_neg_q, out_neg_d;
  logic [2:0]    out_op_q, out_op_d;
  logic          out_valid_q, out_valid_d;
  logic          sticky_q, sticky_d;

  logic          full, empty, push, pop, capture;
  logic          flag_zero, flag_ovf, flag_neg;
  cmd_t          wr_cmd, head;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = in_valid && !full;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    wr_cmd    = '0;
    wr_cmd.op = in_opcode;
    wr_cmd.a  = in_a;
    wr_cmd.b  = in_b;
`ifdef ALU_SEQ_CHAIN_EN
    wr_cmd.chain = in_chain;
`endif
  end

  // NOTE: the command store has no reset; an entry is only ever read while count_q
  // says it holds a pushed command, so its power-up contents never reach an output.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_cmd;
  end

  // Undefined (x/z) flag bits from the ALU resolve to 0; bits the opcode does not
  // define are masked off entirely.
  always_comb begin
    flag_zero = (alu_d[0] === 1'b1);
    flag_ovf  = 1'b0;
    flag_neg  = 1'b0;
    unique case (alu_op_q)
      OP_SLA, OP_ADD, OP_SUB, OP_MUL: begin
        flag_ovf = (alu_d[1] === 1'b1);
        flag_neg = (alu_d[2] === 1'b1);
      end
      OP_SRA:  flag_neg = (alu_d[2] === 1'b1);
      default: ;
    endcase
  end

  // NOTE: every combinational output gets a default before any branch, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    capture     = 1'b0;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    out_c_d     = out_c_q;
    out_zero_d  = out_zero_q;
    out_ovf_d   = out_ovf_q;
    out_neg_d   = out_neg_q;
    out_op_d    = out_op_q;
    out_valid_d = out_valid_q;
    sticky_d    = sticky_q;

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        capture = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!empty) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A chained entry takes the result still held in out_c_q, i.e. the previous command's.
    if (pop) begin
`ifdef ALU_SEQ_CHAIN_EN
      alu_a_d = head.chain ? out_c_q : head.a;
`else
      alu_a_d = head.a;
`endif
      alu_b_d  = head.b;
      alu_op_d = head.op;
    end

    if (capture) begin
      out_c_d     = alu_c;
      out_zero_d  = flag_zero;
      out_ovf_d   = flag_ovf;
      out_neg_d   = flag_neg;
      out_op_d    = alu_op_q;
      out_valid_d = 1'b1;
    end

    if (clr_sticky)           sticky_d = 1'b0;
    if (capture && flag_ovf)  sticky_d = 1'b1;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      out_c_q     <= '0;
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_neg_q   <= 1'b0;
      out_op_q    <= '0;
      out_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      out_c_q     <= out_c_d;
      out_zero_q  <= out_zero_d;
      out_ovf_q   <= out_ovf_d;
      out_neg_q   <= out_neg_d;
      out_op_q    <= out_op_d;
      out_valid_q <= out_valid_d;
      sticky_q    <= sticky_d;
    end
  end

  assign in_ready   = !full;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign out_valid  = out_valid_q;
  assign out_c      = out_c_q;
  assign out_zero   = out_zero_q;
  assign out_ovf    = out_ovf_q;
  assign out_neg    = out_neg_q;
  assign out_opcode = out_op_q;
  assign ovf_sticky = sticky_q;
  assign busy       = (state_q != IDLE) || !empty;
  assign fifo_count = count_q;

endmodule
